// File: rtl/hilo_muldiv_unit_if.sv
// Execute-stage bus between the EX pipeline control and the HI/LO multiply/divide unit.
// master (pipeline) drives: valid_in, hilo_rwen, mul_sign, div, src_a, src_b, cancel
// slave  (unit)     drives: hilo_rdata, stall, busy
interface hilo_muldiv_unit_if;
  logic        valid_in;
  logic [3:0]  hilo_rwen;   // [3]=rd HI, [2]=rd LO, [1]=wr HI, [0]=wr LO; 4'b0011 = mul/div
  logic        mul_sign;
  logic        div;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        cancel;
  logic [31:0] hilo_rdata;
  logic        stall;
  logic        busy;

  modport master (
    output valid_in, hilo_rwen, mul_sign, div, src_a, src_b, cancel,
    input  hilo_rdata, stall, busy
  );

  modport slave (
    input  valid_in, hilo_rwen, mul_sign, div, src_a, src_b, cancel,
    output hilo_rdata, stall, busy
  );
endinterface

// File: rtl/hilo_muldiv_unit.sv
// HI/LO register pair with single-cycle MULT/MULTU, MTHI/MTLO, MFHI/MFLO and a 33-cycle
// restoring DIV/DIVU that stalls the pipeline.
// Ports:
//   clk    - rising-edge clock
//   resetn - asynchronous active-low reset
//   bus    - slave side of hilo_muldiv_unit_if (controls, operands, rdata, stall, busy)
module hilo_muldiv_unit #(
  parameter logic [31:0] HILO_RST = 32'h0000_0000
) (
  input logic              clk,
  input logic              resetn,
  hilo_muldiv_unit_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e      state_q, state_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [31:0] dvd_q, dvd_d;   // dividend magnitude, consumed MSB first
  logic [31:0] dvs_q, dvs_d;   // divisor magnitude
  logic [31:0] rem_q, rem_d;
  logic [31:0] quot_q, quot_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        qneg_q, qneg_d, rneg_q, rneg_d;

  logic        wr, start, a_neg, b_neg, step_ok;
  logic [31:0] a_abs, b_abs;
  logic [63:0] op_a, op_b, prod;
  logic [32:0] rem_shift, diff;

  always_comb begin
    wr    = bus.valid_in & ~bus.cancel;
    start = wr & bus.div & (bus.hilo_rwen == 4'b0011);
    a_neg = bus.mul_sign & bus.src_a[31];
    b_neg = bus.mul_sign & bus.src_b[31];
    a_abs = a_neg ? -bus.src_a : bus.src_a;
    b_abs = b_neg ? -bus.src_b : bus.src_b;
    // Low 64 bits of the sign/zero-extended product are the correct signed or unsigned result
    op_a  = {{32{a_neg}}, bus.src_a};
    op_b  = {{32{b_neg}}, bus.src_b};
    prod  = op_a * op_b;
    // One restoring step: bring in the next dividend bit, subtract divisor if it fits
    rem_shift = {rem_q, dvd_q[31]};
    diff      = rem_shift - {1'b0, dvs_q};
    step_ok   = ~diff[32];
  end

  always_comb begin
    state_d   = state_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    dvd_d     = dvd_q;
    dvs_d     = dvs_q;
    rem_d     = rem_q;
    quot_d    = quot_q;
    cnt_d     = cnt_q;
    qneg_d    = qneg_q;
    rneg_d    = rneg_q;
    bus.stall = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (wr) begin
          unique case (bus.hilo_rwen)
            4'b0010: hi_d = bus.src_a;
            4'b0001: lo_d = bus.src_a;
            4'b0011: begin
              if (bus.div) begin
                dvd_d     = a_abs;
                dvs_d     = b_abs;
                rem_d     = '0;
                quot_d    = '0;
                cnt_d     = '0;
                qneg_d    = a_neg ^ b_neg;
                rneg_d    = a_neg;
                state_d   = StRun;
                bus.stall = 1'b1;
              end else begin
                {hi_d, lo_d} = prod;
              end
            end
            default: ;
          endcase
        end
      end
      StRun: begin
        if (bus.cancel) begin
          state_d = StIdle;
        end else begin
          bus.stall = 1'b1;
          rem_d     = step_ok ? diff[31:0] : rem_shift[31:0];
          quot_d    = {quot_q[30:0], step_ok};
          dvd_d     = {dvd_q[30:0], 1'b0};
          cnt_d     = cnt_q + 5'd1;
          if (cnt_q == 5'd31) state_d = StDone;
        end
      end
      StDone: begin
        // Pipeline is released this cycle; held operands must not restart a division
        if (!bus.cancel) begin
          hi_d = rneg_q ? -rem_q : rem_q;
          lo_d = qneg_q ? -quot_q : quot_q;
        end
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    bus.busy = (state_q != StIdle);
    unique case (bus.hilo_rwen)
      4'b1000: bus.hilo_rdata = hi_q;
      4'b0100: bus.hilo_rdata = lo_q;
      default: bus.hilo_rdata = '0;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= StIdle;
      hi_q    <= HILO_RST;
      lo_q    <= HILO_RST;
      dvd_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      quot_q  <= '0;
      cnt_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      rem_q   <= rem_d;
      quot_q  <= quot_d;
      cnt_q   <= cnt_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
    end
  end

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Self-checking bench for hilo_muldiv_unit: directed vector table, multi-cycle corner
// sequences (cancel, async reset mid-divide) and randomized ops against an arithmetic model.
module tb_hilo_muldiv_unit;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  hilo_muldiv_unit_if bus();

  hilo_muldiv_unit #(.HILO_RST(32'h0000_0000)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  int unsigned checks = 0;
  int unsigned failures = 0;
  logic [31:0] m_hi, m_lo;

  typedef struct {
    string       name;
    logic [3:0]  rwen;
    logic        sign;
    logic        dv;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.valid_in  = 1'b0;
    bus.hilo_rwen = 4'b0000;
    bus.mul_sign  = 1'b0;
    bus.div       = 1'b0;
    bus.src_a     = '0;
    bus.src_b     = '0;
    bus.cancel    = 1'b0;
  endtask

  task automatic drive(input logic [3:0] rwen, input logic sign, input logic dv,
                       input logic [31:0] a, input logic [31:0] b);
    bus.valid_in  = 1'b1;
    bus.hilo_rwen = rwen;
    bus.mul_sign  = sign;
    bus.div       = dv;
    bus.src_a     = a;
    bus.src_b     = b;
    bus.cancel    = 1'b0;
  endtask

  // All tasks start and end 1 time unit after a rising edge.
  task automatic do_op(input logic [3:0] rwen, input logic sign, input logic dv,
                       input logic [31:0] a, input logic [31:0] b);
    drive(rwen, sign, dv, a, b);
    @(posedge clk); #1;
    idle_inputs();
  endtask

  task automatic read_check(input string name, input logic [31:0] exp_hi,
                            input logic [31:0] exp_lo);
    drive(4'b1000, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    check({name, ".mfhi"}, bus.hilo_rdata, exp_hi);
    @(posedge clk); #1;
    drive(4'b0100, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    check({name, ".mflo"}, bus.hilo_rdata, exp_lo);
    @(posedge clk); #1;
    idle_inputs();
  endtask

  // Operands stay held through DONE, as a stalled pipeline would present them.
  task automatic run_div(input string name, input logic sign, input logic [31:0] a,
                         input logic [31:0] b);
    int n = 0;
    bit done = 1'b0;
    drive(4'b0011, sign, 1'b1, a, b);
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (bus.stall) n++;
      else done = 1'b1;
      if (!done) begin
        @(posedge clk); #1;
      end
    end
    check({name, ".stall_cycles"}, 32'(n), 32'd33);
    check({name, ".busy_in_done"}, {31'b0, bus.busy}, 32'd1);
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    check({name, ".no_restart"}, {31'b0, bus.busy}, 32'd0);
    @(posedge clk); #1;
  endtask

  function automatic void model(input logic [3:0] rwen, input logic sign, input logic dv,
                                input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, sq, sr;
    longint unsigned up;
    logic [31:0] mag_a;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (rwen)
      4'b0010: m_hi = a;
      4'b0001: m_lo = a;
      4'b0011: begin
        if (!dv) begin
          if (sign) begin
            sq = sa * sb;
            {m_hi, m_lo} = sq;
          end else begin
            up = {32'h0, a} * {32'h0, b};
            {m_hi, m_lo} = up;
          end
        end else if (b == 32'h0) begin
          // Raw iteration result: all-ones quotient, |dividend| remainder, then signs
          mag_a = (sign && a[31]) ? -a : a;
          m_lo  = (sign && (a[31] ^ b[31])) ? -32'hFFFF_FFFF : 32'hFFFF_FFFF;
          m_hi  = (sign && a[31]) ? -mag_a : mag_a;
        end else if (sign) begin
          sq = sa / sb;
          sr = sa % sb;
          m_lo = sq[31:0];
          m_hi = sr[31:0];
        end else begin
          m_lo = a / b;
          m_hi = a % b;
        end
      end
      default: ;
    endcase
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 6))
      0: return 32'h0000_0000;
      1: return 32'h0000_0001;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'($urandom_range(0, 255));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{"mthi",      4'b0010, 1'b0, 1'b0, 32'h1234_5678, 32'h0, 32'h1234_5678, 32'h0};
    vecs[1] = '{"multu_ff",  4'b0011, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                32'hFFFF_FFFE, 32'h0000_0001};
    vecs[2] = '{"mult_ff",   4'b0011, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                32'h0, 32'h1};
    vecs[3] = '{"mtlo",      4'b0001, 1'b0, 1'b0, 32'hDEAD_BEEF, 32'h0, 32'h0, 32'hDEAD_BEEF};
    vecs[4] = '{"divu_100_7", 4'b0011, 1'b0, 1'b1, 32'd100, 32'd7, 32'd2, 32'd14};
    vecs[5] = '{"div_7_m2",  4'b0011, 1'b1, 1'b1, 32'd7, 32'hFFFF_FFFE,
                32'h1, 32'hFFFF_FFFD};
    vecs[6] = '{"div_m7_2",  4'b0011, 1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2,
                32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[7] = '{"div_min_m1", 4'b0011, 1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF,
                32'h0, 32'h8000_0000};
    vecs[8] = '{"rwen_0111", 4'b0111, 1'b0, 1'b0, 32'h1111_1111, 32'h2222_2222,
                32'h0, 32'h8000_0000};
    vecs[9] = '{"mult_m2_3", 4'b0011, 1'b1, 1'b0, 32'hFFFF_FFFE, 32'd3,
                32'hFFFF_FFFF, 32'hFFFF_FFFA};

    // Reset state
    idle_inputs();
    bus.hilo_rwen = 4'b1000;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset.hi", bus.hilo_rdata, 32'h0);
    check("reset.stall", {31'b0, bus.stall}, 32'd0);
    check("reset.busy", {31'b0, bus.busy}, 32'd0);
    bus.hilo_rwen = 4'b0100;
    #1 check("reset.lo", bus.hilo_rdata, 32'h0);
    resetn = 1'b1;
    @(posedge clk); #1;
    idle_inputs();

    // Directed vector table
    foreach (vecs[i]) begin
      if (vecs[i].rwen == 4'b0011 && vecs[i].dv)
        run_div(vecs[i].name, vecs[i].sign, vecs[i].a, vecs[i].b);
      else
        do_op(vecs[i].rwen, vecs[i].sign, vecs[i].dv, vecs[i].a, vecs[i].b);
      read_check(vecs[i].name, vecs[i].hi, vecs[i].lo);
    end

    // Unlisted read encodings return zero
    drive(4'b1100, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    check("rdata_1100", bus.hilo_rdata, 32'h0);
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    check("rdata_0000", bus.hilo_rdata, 32'h0);
    @(posedge clk); #1;

    // Cancel on RUN cycle 10
    do_op(4'b0010, 1'b0, 1'b0, 32'hAAAA_AAAA, 32'h0);
    do_op(4'b0001, 1'b0, 1'b0, 32'hAAAA_AAAA, 32'h0);
    drive(4'b0011, 1'b0, 1'b1, 32'd100, 32'd7);
    repeat (10) begin
      @(posedge clk); #1;
    end
    bus.cancel = 1'b1;
    @(negedge clk);
    check("cancel_run.stall", {31'b0, bus.stall}, 32'd0);
    check("cancel_run.busy_now", {31'b0, bus.busy}, 32'd1);
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    check("cancel_run.busy_next", {31'b0, bus.busy}, 32'd0);
    @(posedge clk); #1;
    read_check("cancel_run", 32'hAAAA_AAAA, 32'hAAAA_AAAA);

    // Cancel in IDLE suppresses start and writes
    drive(4'b0011, 1'b0, 1'b1, 32'd9, 32'd3);
    bus.cancel = 1'b1;
    @(negedge clk);
    check("cancel_idle.stall", {31'b0, bus.stall}, 32'd0);
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    check("cancel_idle.busy", {31'b0, bus.busy}, 32'd0);
    @(posedge clk); #1;
    drive(4'b0010, 1'b0, 1'b0, 32'h5555_5555, 32'h0);
    bus.cancel = 1'b1;
    @(posedge clk); #1;
    drive(4'b0011, 1'b0, 1'b0, 32'd3, 32'd3);
    bus.cancel = 1'b1;
    @(posedge clk); #1;
    idle_inputs();
    read_check("cancel_idle", 32'hAAAA_AAAA, 32'hAAAA_AAAA);

    // Asynchronous reset mid-division
    drive(4'b0011, 1'b0, 1'b1, 32'd100, 32'd7);
    repeat (6) begin
      @(posedge clk); #1;
    end
    #2;
    resetn = 1'b0;
    idle_inputs();
    #1;
    check("async_rst.busy", {31'b0, bus.busy}, 32'd0);
    check("async_rst.stall", {31'b0, bus.stall}, 32'd0);
    #2 resetn = 1'b1;
    @(posedge clk); #1;
    read_check("async_rst", 32'h0, 32'h0);
    run_div("divu_5_0", 1'b0, 32'd5, 32'd0);
    read_check("divu_5_0", 32'd5, 32'hFFFF_FFFF);

    // Randomized ops against the arithmetic model
    m_hi = 32'd5;
    m_lo = 32'hFFFF_FFFF;
    for (int i = 0; i < 30; i++) begin
      logic [31:0] a, b;
      int k;
      a = pick_operand();
      b = pick_operand();
      k = int'($urandom_range(0, 5));
      case (k)
        0: begin do_op(4'b0010, 1'b0, 1'b0, a, b); model(4'b0010, 1'b0, 1'b0, a, b); end
        1: begin do_op(4'b0001, 1'b0, 1'b0, a, b); model(4'b0001, 1'b0, 1'b0, a, b); end
        2: begin do_op(4'b0011, 1'b1, 1'b0, a, b); model(4'b0011, 1'b1, 1'b0, a, b); end
        3: begin do_op(4'b0011, 1'b0, 1'b0, a, b); model(4'b0011, 1'b0, 1'b0, a, b); end
        4: begin run_div("rnd_div", 1'b1, a, b); model(4'b0011, 1'b1, 1'b1, a, b); end
        default: begin run_div("rnd_divu", 1'b0, a, b); model(4'b0011, 1'b0, 1'b1, a, b); end
      endcase
      read_check($sformatf("rnd%0d_op%0d_a%h_b%h", i, k, a, b), m_hi, m_lo);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
